// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings
// and the iteration-counter width helper.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement unit: passes i_val through, or negates it when
// i_neg is set. Used for operand magnitudes and for the final product sign.
module seq_mult_abs #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with per-operation signed/unsigned mode.
// Define SEQ_MULT_EARLY_TERM_EN to stop iterating once the multiplier runs out of set bits.
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_is_signed,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_p
);

   localparam int CW = cnt_width(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t           r_state;
   state_t           w_state_next;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;
   logic [PW-1:0]    r_p;

   logic             w_accept;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [PW-1:0]    w_acc_next;
   logic [PW-1:0]    w_p_final;
   logic [WIDTH-1:0] w_mplier_shift;
   logic             w_last;

   // A new request is taken in IDLE and DONE alike; RUN ignores start.
   assign w_accept = i_start && (r_state != ST_RUN);

   seq_mult_abs #(.W(WIDTH)) u_abs_a (
      .i_val (i_a),
      .i_neg (i_is_signed & i_a[WIDTH-1]),
      .o_val (w_a_mag)
   );

   seq_mult_abs #(.W(WIDTH)) u_abs_b (
      .i_val (i_b),
      .i_neg (i_is_signed & i_b[WIDTH-1]),
      .o_val (w_b_mag)
   );

   assign w_acc_next     = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mplier_shift = r_mplier >> 1;

   // Sign is applied to the accumulator value that includes the final iteration.
   seq_mult_abs #(.W(PW)) u_abs_p (
      .i_val (w_acc_next),
      .i_neg (r_neg),
      .o_val (w_p_final)
   );

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_shift == '0);
`else
   assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: w_state_next = w_accept ? ST_RUN : ST_IDLE;
         ST_RUN:  w_state_next = w_last ? ST_DONE : ST_RUN;
         ST_DONE: w_state_next = w_accept ? ST_RUN : ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state == ST_RUN);
      o_done = (r_state == ST_DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_p      <= '0;
      end else if (w_accept) begin
         r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplier <= w_b_mag;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      end else if (r_state == ST_RUN) begin
         // Shifting the multiplicand each step realises "shifted by iteration index".
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= w_mplier_shift;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) begin
            r_p <= w_p_final;
         end
      end
   end

   assign o_p = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8); the early-termination
// expectations follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;

   logic        clk;
   logic        i_rst;
   logic        i_start;
   logic        i_is_signed;
   logic [7:0]  i_a;
   logic [7:0]  i_b;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_p;

   int          n_cmp;
   int          n_mis;
   logic [15:0] held_p;

   seq_multiplier #(.WIDTH(8)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_is_signed (i_is_signed),
      .i_a         (i_a),
      .i_b         (i_b),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_p         (o_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected latency (start edge to done cycle) from the multiplier magnitude.
   function automatic int exp_lat(input logic sgn, input logic [7:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
      logic [7:0] mag;
      int         k;
      mag = (sgn && b[7]) ? (~b + 8'd1) : b;
      k = 1;
      for (int i = 0; i < 8; i++) if (mag[i]) k = i + 1;
      return k + 1;
`else
      return 9;
`endif
   endfunction

   // Called at the falling edge of cycle T; returns at the falling edge of the done cycle.
   task automatic run_op(input string tag, input logic sgn, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp, input int lat,
                         input int glitch);
      i_start     = 1'b1;
      i_is_signed = sgn;
      i_a         = a;
      i_b         = b;
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         i_start = (i == glitch);
         if (i == glitch) begin
            i_is_signed = 1'b0;
            i_a         = 8'h11;
            i_b         = 8'h22;
         end
         chk({tag, "_busy"}, 32'(o_busy), 32'd1);
         chk({tag, "_nodone"}, 32'(o_done), 32'd0);
         chk({tag, "_hold"}, 32'(o_p), 32'(held_p));
      end
      @(negedge clk);
      i_start = 1'b0;
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      chk({tag, "_busy0"}, 32'(o_busy), 32'd0);
      chk({tag, "_p"}, 32'(o_p), 32'(exp));
      $display("op %s: a=%h b=%h signed=%0d p=%h expected %h", tag, a, b, sgn, o_p, exp);
      held_p = exp;
   endtask

   task automatic idle_cycle(input string tag);
      @(negedge clk);
      chk({tag, "_idle_done"}, 32'(o_done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      held_p      = 16'h0000;
      i_rst       = 1'b1;
      i_start     = 1'b0;
      i_is_signed = 1'b0;
      i_a         = 8'h00;
      i_b         = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_p", 32'(o_p), 32'd0);
      i_rst = 1'b0;

      run_op("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, exp_lat(1'b0, 8'hFF), 0);
      idle_cycle("u_ff_ff");

      run_op("u_03_ff", 1'b0, 8'h03, 8'hFF, 16'h02FD, exp_lat(1'b0, 8'hFF), 0);
      idle_cycle("u_03_ff");
      run_op("s_03_ff", 1'b1, 8'h03, 8'hFF, 16'hFFFD, exp_lat(1'b1, 8'hFF), 0);
      idle_cycle("s_03_ff");
      run_op("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000, exp_lat(1'b1, 8'h80), 0);
      idle_cycle("s_80_80");

      // Back-to-back: second start is raised in the first done cycle.
      run_op("b2b_1", 1'b0, 8'h12, 8'h34, 16'h03A8, exp_lat(1'b0, 8'h34), 0);
      run_op("b2b_2", 1'b0, 8'h0A, 8'h0B, 16'h006E, exp_lat(1'b0, 8'h0B), 0);
      idle_cycle("b2b");

      // Start pulsed at T+3 while busy must be ignored.
      run_op("ign", 1'b0, 8'h05, 8'h81, 16'h0285, exp_lat(1'b0, 8'h81), 3);
      idle_cycle("ign");

      // Reset at T+4 aborts the operation.
      i_start     = 1'b1;
      i_is_signed = 1'b0;
      i_a         = 8'h12;
      i_b         = 8'h9C;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         i_start = 1'b0;
         chk("abort_busy_pre", 32'(o_busy), 32'd1);
      end
      i_rst = 1'b1;
      #1;
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_done", 32'(o_done), 32'd0);
      chk("abort_p", 32'(o_p), 32'd0);
      held_p = 16'h0000;
      @(negedge clk);
      i_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(o_done), 32'd0);
         chk("abort_nobusy", 32'(o_busy), 32'd0);
      end
      chk("abort_p_held", 32'(o_p), 32'd0);

      run_op("s_fe_05", 1'b1, 8'hFE, 8'h05, 16'hFFF6, exp_lat(1'b1, 8'h05), 0);
      idle_cycle("s_fe_05");

`ifdef SEQ_MULT_EARLY_TERM_EN
      run_op("et_07_03", 1'b0, 8'h07, 8'h03, 16'h0015, 3, 0);
      idle_cycle("et_07_03");
      run_op("et_b0", 1'b0, 8'h5A, 8'h00, 16'h0000, 2, 0);
      idle_cycle("et_b0");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with a per-operation signed/unsigned mode select, replacing fixed-width combinational multipliers where area matters more than latency. It accepts one operand pair on a `start` pulse and iterates one multiplier bit per clock. It returns a full-width product with a one-cycle `done` pulse. It sits between a requesting datapath/controller and any consumer of the product, and is the generalised, multi-cycle successor of the 4-bit mode-selectable multiplier.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `is_signed`  in  1  mode select: 0 = unsigned, 1 = two's-complement. Sampled with `start`.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `p` is valid in this cycle.
- `p`  out  2*WIDTH  product; held until the next `done`.

## Operation
- FSM states:
  - IDLE: `start`=1 latches operands, clears the accumulator and the iteration counter, then goes to RUN.
  - RUN: one iteration per cycle. After the last iteration, goes to DONE.
  - DONE: `done`=1 for this cycle. `start`=1 here is accepted exactly as in IDLE and goes to RUN; otherwise goes to IDLE.
- Operand preparation at latch:
  - Unsigned mode: magnitudes are `a` and `b` unchanged. The result sign flag is 0.
  - Signed mode: magnitudes are |a| and |b| as WIDTH-bit unsigned values; -2^(WIDTH-1) maps to 2^(WIDTH-1), which is representable. The result sign flag is sign(a) XOR sign(b).
- Each iteration:
  - If the multiplier LSB is 1, add the multiplicand magnitude, shifted by the iteration index, into the 2*WIDTH accumulator.
  - Then shift the multiplier right by one.
- On the transition into DONE, write `p` as the accumulator, two's-complement negated if the sign flag is set. Any zero product yields `p`=0 with no negative zero.
- Product width is exact: no overflow is possible in either mode. Example: (-2^(W-1))² = 2^(2W-2), which fits in the signed 2W range.
- `start` while in RUN is ignored; there is no queueing. Operand inputs are don't-care except in the `start` cycle.

## Timing
- `start` is sampled at the edge ending cycle T.
- `busy`=1 in cycles T+1..T+WIDTH, i.e. WIDTH RUN cycles.
- `done`=1 in cycle T+WIDTH+1, with `busy`=0. `p` updates at the start of that cycle.
- With `start` held high continuously, throughput is one result per WIDTH+1 cycles.
- Reset values: `busy`=0, `done`=0, `p`=0, FSM state = IDLE.
- Reset asserted mid-operation aborts the operation immediately: no `done` is issued and `p` returns to 0.
- The first edge after deassertion may sample `start`.

## Configuration
- `SEQ_MULT_EARLY_TERM_EN` defined: RUN exits after any iteration whose post-shift multiplier is zero, or after WIDTH iterations, whichever comes first.
  - Latency becomes k+1 cycles, where k = max(1, index of the highest set bit of the multiplier magnitude + 1).
  - For |b|=0, `done` is at T+2.
- Undefined: latency is fixed at WIDTH+1 for all operands.

## Structure
- Shared package/include `seq_mult_pkg`: FSM state encodings (IDLE, RUN, DONE) and the counter-width helper ($clog2(WIDTH+1)).
- One natural sub-module: `seq_mult_abs`, a WIDTH-bit conditional two's-complement magnitude unit. It is instantiated for `a`, for `b`, and at 2*WIDTH for the final negation.

## Test plan
All scenarios use WIDTH=8 with the macro undefined, except scenario 6.
1. Unsigned, `a`=0xFF, `b`=0xFF, `start` in cycle T -> `busy` in T+1..T+8; `done` only in T+9 with `p`=0xFE01.
2. Mode contrast:
   - Unsigned `a`=0x03, `b`=0xFF -> `p`=0x02FD.
   - Signed same operands -> `p`=0xFFFD (-3).
   - Signed `a`=0x80, `b`=0x80 -> `p`=0x4000.
3. Back-to-back: keep `start`=1 with new operands in the `done` cycle -> the second `done` comes exactly 9 cycles later with the second product. The first `p` is held in between.
4. `start` pulsed with different operands at T+3 (while busy) -> ignored; the result equals the first request and `done` stays at T+9.
5. `rst` asserted at T+4 mid-operation -> `busy`/`done`/`p` are 0 asynchronously. No later `done` appears until a new `start`.
6. Macro defined:
   - Unsigned `a`=0x07, `b`=0x03 -> `done` at T+3, `p`=0x0015.
   - `b`=0 -> `done` at T+2, `p`=0.
